// File: rtl/tx_scheduler.sv
// Round-robin packet scheduler feeding the shared UART TX escape stage.
// Each packet is one escaped command byte followed by LEN payload bytes, paced by a guard window.
module tx_scheduler #(
    parameter int unsigned LEN_W        = 8,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic               CLK_I,
    input  logic               RST_NI,
    input  logic [1:0]         REQ_I,
    input  logic [15:0]        CMD_I,
    input  logic [2*LEN_W-1:0] LEN_I,
    input  logic [15:0]        DATA_I,
    input  logic [1:0]         VALID_I,
    output logic [1:0]         ACK_O,
    output logic [1:0]         GNT_O,
    output logic [1:0]         DONE_O,
    output logic               BUSY_O,
    input  logic               TX_READY_I,
    output logic [7:0]         DATA_SEND_O,
    output logic               WRITE_O,
    output logic [7:0]         COMMAND_O,
    output logic               WRITE_COMMAND_O
);

    localparam int unsigned GW = (GUARD_CYCLES < 3) ? 1 : $clog2(GUARD_CYCLES);

    typedef enum logic [2:0] {IDLE, CMD, GUARD, DATA, DONE} state_t;

    state_t           state, state_nxt;
    logic             idx;
    logic             last_grant;
    logic [7:0]       cmd_q;
    logic [LEN_W-1:0] rem_q;
    logic [GW-1:0]    guard_q;

    logic             req_any, pick, valid_g;
    logic             accept_cmd, accept_data, guard_end;
    logic [7:0]       cmd_in, data_in;
    logic [LEN_W-1:0] len_in;

    logic [1:0]       gnt_d, done_d;
    logic             busy_d, write_d, write_cmd_d;
    logic [7:0]       command_d, data_d;

    // Contention goes to the requester that did not win last time.
    assign req_any     = |REQ_I;
    assign pick        = (REQ_I == 2'b11) ? ~last_grant : REQ_I[1];
    assign cmd_in      = pick ? CMD_I[15:8] : CMD_I[7:0];
    assign len_in      = pick ? LEN_I[2*LEN_W-1:LEN_W] : LEN_I[LEN_W-1:0];
    assign data_in     = idx ? DATA_I[15:8] : DATA_I[7:0];
    assign valid_g     = idx ? VALID_I[1] : VALID_I[0];
    assign accept_cmd  = (state == CMD) && TX_READY_I;
    assign accept_data = (state == DATA) && TX_READY_I && valid_g;
    assign guard_end   = (state == GUARD) && (guard_q == GW'(GUARD_CYCLES - 1));
    assign ACK_O       = {accept_data & idx, accept_data & ~idx};

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = CMD;
            CMD:     if (TX_READY_I) state_nxt = GUARD;
            GUARD:   if (guard_end) state_nxt = (rem_q != '0) ? DATA : DONE;
            DATA:    if (accept_data) state_nxt = GUARD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = GNT_O;
        done_d      = 2'b00;
        busy_d      = (state_nxt != IDLE);
        write_d     = accept_data;
        write_cmd_d = accept_cmd;
        command_d   = COMMAND_O;
        data_d      = DATA_SEND_O;
        if ((state == IDLE) && req_any) gnt_d = {pick, ~pick};
        if (state == DONE) begin
            gnt_d  = 2'b00;
            done_d = {idx, ~idx};
        end
        if (accept_cmd)  command_d = cmd_q;
        if (accept_data) data_d    = data_in;
    end

    // Packet context: latched at grant so requester changes mid-packet are ignored.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            idx        <= 1'b0;
            last_grant <= 1'b1;
            cmd_q      <= '0;
            rem_q      <= '0;
            guard_q    <= '0;
        end else begin
            if ((state == IDLE) && req_any) begin
                idx   <= pick;
                cmd_q <= cmd_in;
                rem_q <= len_in;
            end
            if (accept_data && (rem_q != '0)) rem_q <= rem_q - LEN_W'(1);
            if (accept_cmd || accept_data)             guard_q <= '0;
            else if ((state == GUARD) && !guard_end)   guard_q <= guard_q + GW'(1);
            if (state == DONE) last_grant <= idx;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            GNT_O           <= 2'b00;
            DONE_O          <= 2'b00;
            BUSY_O          <= 1'b0;
            WRITE_O         <= 1'b0;
            WRITE_COMMAND_O <= 1'b0;
            COMMAND_O       <= '0;
            DATA_SEND_O     <= '0;
        end else begin
            GNT_O           <= gnt_d;
            DONE_O          <= done_d;
            BUSY_O          <= busy_d;
            WRITE_O         <= write_d;
            WRITE_COMMAND_O <= write_cmd_d;
            COMMAND_O       <= command_d;
            DATA_SEND_O     <= data_d;
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: directed packets push expected strobes, a monitor pops and compares.
module tb_tx_scheduler;

    typedef struct {
        int kind;   // 0 command strobe, 1 data strobe, 2 done pulse
        int val;
        int req;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] cmd = '0;
    logic [15:0] len = '0;
    logic [15:0] data;
    logic [1:0]  valid;
    logic [1:0]  ack, gnt, done;
    logic        busy, tx_ready, write_s, write_cmd;
    logic [7:0]  data_send, command;

    logic        ready_force = 1'b1;
    logic        model_ready = 1'b1;
    logic        model_en = 1'b0;
    logic [1:0]  valid_en = 2'b11;
    logic [1:0]  ack_seen;
    logic [7:0]  pl0 [32];
    logic [7:0]  pl1 [32];
    int          n0 = 0, n1 = 0, p0 = 0, p1 = 0;
    int          checks = 0, fails = 0;
    int          cyc = 0, last_strobe = 0, strobe_cnt = 0;
    int          ack0_cnt = 0, ack1_cnt = 0, mk;
    bit          have_last = 0;
    logic        prev_ready = 1'b0;
    ev_t         exp_q[$];
    logic [7:0]  uart_log[$];

    assign tx_ready    = ready_force & model_ready;
    assign valid[0]    = valid_en[0] && (p0 < n0);
    assign valid[1]    = valid_en[1] && (p1 < n1);
    assign data[7:0]   = pl0[p0[4:0]];
    assign data[15:8]  = pl1[p1[4:0]];

    tx_scheduler #(.LEN_W(8), .GUARD_CYCLES(2)) dut (
        .CLK_I(clk), .RST_NI(rst_n), .REQ_I(req), .CMD_I(cmd), .LEN_I(len),
        .DATA_I(data), .VALID_I(valid), .ACK_O(ack), .GNT_O(gnt), .DONE_O(done),
        .BUSY_O(busy), .TX_READY_I(tx_ready), .DATA_SEND_O(data_send), .WRITE_O(write_s),
        .COMMAND_O(command), .WRITE_COMMAND_O(write_cmd)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input int v, input int r);
        ev_t e;
        e.kind = k; e.val = v; e.req = r;
        exp_q.push_back(e);
    endtask

    task automatic strobe_ev(input int k, input int v);
        ev_t e;
        strobe_cnt++;
        check("strobe_after_ready", int'(prev_ready), 1);
        if (have_last) check("strobe_spacing", int'((cyc - last_strobe) >= 3), 1);
        last_strobe = cyc;
        have_last = 1;
        if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_strobe: got kind %0d value 0x%0h, expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_value", v, e.val);
            check("gnt_at_strobe", int'(gnt), 1 << e.req);
        end
    endtask

    task automatic done_ev();
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_done: got 0x%0h, expected none", done);
        end else begin
            e = exp_q.pop_front();
            check("done_kind", 2, e.kind);
            check("done_onehot", int'(done), 1 << e.req);
            check("gnt_cleared_at_done", int'(gnt), 0);
            check("done_after_strobe", cyc - last_strobe, 3);
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("excl", int'(gnt == 2'b11 || (write_s && write_cmd)), 0);
            if (ack != 2'b00) begin
                if (ack[0]) ack0_cnt++;
                if (ack[1]) ack1_cnt++;
                check("ack_needs_ready", int'(tx_ready), 1);
            end
            if (write_cmd)     strobe_ev(0, int'(command));
            if (write_s)       strobe_ev(1, int'(data_send));
            if (done != 2'b00) done_ev();
            prev_ready = tx_ready;
        end
    end

    // Payload sources advance after each acknowledged byte.
    initial forever begin
        @(negedge clk);
        ack_seen = ack;
        @(posedge clk);
        #1;
        if (ack_seen[0]) p0++;
        if (ack_seen[1]) p1++;
    end

    // Escape-stage model: ready drops 2 cycles after a strobe, longer for an escaped 0xB1.
    initial forever begin
        @(negedge clk);
        if (model_en && rst_n && (write_s || write_cmd)) begin
            if (write_s) uart_log.push_back(data_send);
            mk = (write_s && data_send == 8'hB1) ? 3 : 1;
            @(posedge clk);
            @(posedge clk);
            #1 model_ready = 1'b0;
            repeat (mk) @(posedge clk);
            #1 model_ready = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input logic [1:0] g, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (gnt !== g && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(gnt), int'(g));
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic int all_outs();
        return int'({gnt, done, busy, write_s, write_cmd, command, data_send, ack});
    endfunction

    initial begin
        int s, a, base, n;
        do_reset();
        check("reset_outputs", all_outs(), 0);

        // T1: single packet, two payload bytes
        pl0[n0] = 8'h11; n0++;
        pl0[n0] = 8'h22; n0++;
        cmd[7:0] = 8'h05; len[7:0] = 8'd2;
        expect_ev(0, 'h05, 0); expect_ev(1, 'h11, 0); expect_ev(1, 'h22, 0); expect_ev(2, 0, 0);
        a = ack0_cnt;
        tick(); req = 2'b01;
        wait_gnt(2'b01, "t1_grant");
        req = 2'b00;
        wait_empty("t1_complete");
        check("t1_ack_count", ack0_cnt - a, 2);

        // T3: zero-length packet
        cmd[7:0] = 8'hA3; len[7:0] = 8'd0;
        expect_ev(0, 'hA3, 0); expect_ev(2, 0, 0);
        tick(); req = 2'b01;
        wait_gnt(2'b01, "t3_grant");
        req = 2'b00;
        wait_empty("t3_complete");

        // T2: both requesting, strict alternation starting at 0
        do_reset();
        pl0[n0] = 8'hA1; n0++; pl0[n0] = 8'hA2; n0++;
        pl1[n1] = 8'hC1; n1++; pl1[n1] = 8'hC2; n1++;
        cmd = 16'h2010; len = {8'd1, 8'd1};
        for (int i = 0; i < 2; i++) begin
            expect_ev(0, 'h10, 0); expect_ev(1, (i == 0) ? 'hA1 : 'hA2, 0); expect_ev(2, 0, 0);
            expect_ev(0, 'h20, 1); expect_ev(1, (i == 0) ? 'hC1 : 'hC2, 1); expect_ev(2, 0, 1);
        end
        tick(); req = 2'b11;
        n = 0;
        while (exp_q.size() > 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tick(); req = 2'b00;
        wait_empty("t2_complete");

        // T4: ready stall in CMD, valid stall in DATA
        pl0[n0] = 8'h4A; n0++; pl0[n0] = 8'h4B; n0++;
        cmd[7:0] = 8'h44; len[7:0] = 8'd2;
        expect_ev(0, 'h44, 0); expect_ev(1, 'h4A, 0); expect_ev(1, 'h4B, 0); expect_ev(2, 0, 0);
        tick(); ready_force = 1'b0; valid_en[0] = 1'b0; req = 2'b01;
        wait_gnt(2'b01, "t4_grant");
        req = 2'b00;
        s = strobe_cnt; a = ack0_cnt;
        repeat (10) @(negedge clk);
        check("t4_no_strobe_ready_low", strobe_cnt - s, 0);
        tick(); ready_force = 1'b1;
        @(negedge clk); check("t4_cmd_not_early", int'(write_cmd), 0);
        @(negedge clk); check("t4_cmd_resume", int'(write_cmd), 1);
        repeat (8) @(negedge clk);
        check("t4_no_strobe_valid_low", strobe_cnt - s, 1);
        check("t4_no_ack_valid_low", ack0_cnt - a, 0);
        tick(); valid_en[0] = 1'b1;
        @(negedge clk); check("t4_ack_resume", int'(ack), 1);
        @(negedge clk); check("t4_data_resume", int'(write_s), 1);
        wait_empty("t4_complete");

        // T5: escape bytes through the busy escape-stage model
        model_en = 1'b1;
        base = uart_log.size();
        pl1[n1] = 8'hB1; n1++; pl1[n1] = 8'hB1; n1++;
        cmd[15:8] = 8'h55; len[15:8] = 8'd2;
        expect_ev(0, 'h55, 1); expect_ev(1, 'hB1, 1); expect_ev(1, 'hB1, 1); expect_ev(2, 0, 1);
        tick(); req = 2'b10;
        wait_gnt(2'b10, "t5_grant");
        req = 2'b00;
        wait_empty("t5_complete");
        check("t5_uart_count", uart_log.size() - base, 2);
        check("t5_uart_b0", int'(uart_log[base]), 'hB1);
        check("t5_uart_b1", int'(uart_log[base + 1]), 'hB1);
        model_en = 1'b0;
        repeat (4) @(negedge clk);

        // T6: reset mid-packet, then a lone requester 1
        for (int i = 0; i < 4; i++) begin pl0[n0] = 8'(8'h61 + i); n0++; end
        cmd[7:0] = 8'h66; len[7:0] = 8'd4;
        expect_ev(0, 'h66, 0); expect_ev(1, 'h61, 0);
        tick(); req = 2'b01;
        wait_gnt(2'b01, "t6_grant");
        req = 2'b00;
        n = 0;
        @(negedge clk);
        while (!write_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_write", int'(write_s), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", all_outs(), 0);
        check("t6_nothing_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        check("t6_no_done_in_reset", int'(done), 0);
        #1 rst_n = 1'b1;
        cmd[15:8] = 8'h77; len[15:8] = 8'd0;
        expect_ev(0, 'h77, 1); expect_ev(2, 0, 1);
        tick(); req = 2'b10;
        wait_gnt(2'b10, "t6_lone_req1_grant");
        req = 2'b00;
        wait_empty("t6_complete");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
